apb_rambus_bridge: RTL



---
 rtl/apb_rambus_bridge.sv | 124 ++++++++++++
 1 files changed

// File: rtl/apb_rambus_bridge.sv
// APB3 slave to DMMainPorts RamBus bridge: each APB transfer is replayed as a
// chip-select / latch-strobe / acknowledge cycle with a bounded wait and error.
module apb_rambus_bridge #(
  parameter int                ADDR_W         = 14,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'h0BAD_BEEF
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              RamBusnCs,
  output logic              RamBusWrnRd,
  output logic              RamBusLatch,
  output logic [ADDR_W-1:0] RamBusAddress,
  output logic [DATA_W-1:0] RamBusDataIn,
  input  logic [DATA_W-1:0] RamBusDataOut,
  input  logic              RamBusAck,
  output logic [15:0]       TimeoutCount,
  output logic [2:0]        fsm_state
);

  // Handshake: an APB setup phase (PSEL=1, PENABLE=0) seen in IDLE starts one
  // RamBus cycle; PREADY pulses for one cycle when it ends, and PSLVERR is
  // meaningful only in that cycle. RamBusAck is a level sampled from LATCH on.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ASSERT = 3'd1,
    S_LATCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] wait_cnt;
  logic        timeout_hit;
  logic        setup;
  logic        enter_done;

  assign fsm_state  = state_q;
  assign setup      = (state_q == S_IDLE) && PSEL && !PENABLE;
  // DONE is only reachable from LATCH or WAIT, so this is a one-cycle event.
  assign enter_done = (state_d == S_DONE);

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE:   if (setup) state_d = S_ASSERT;
      S_ASSERT: state_d = S_LATCH;
      S_LATCH:  state_d = RamBusAck ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (RamBusAck) begin
          state_d = S_DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= S_IDLE;
      wait_cnt      <= '0;
      PRDATA        <= '0;
      PREADY        <= 1'b0;
      PSLVERR       <= 1'b0;
      RamBusnCs     <= 1'b1;
      RamBusWrnRd   <= 1'b0;
      RamBusLatch   <= 1'b0;
      RamBusAddress <= '0;
      RamBusDataIn  <= '0;
      TimeoutCount  <= '0;
    end else begin
      state_q     <= state_d;
      // Outputs are decoded from the next state so they line up with it.
      RamBusnCs   <= !((state_d == S_ASSERT) || (state_d == S_LATCH) ||
                       (state_d == S_WAIT));
      RamBusLatch <= (state_d == S_LATCH);
      PREADY      <= enter_done;
      PSLVERR     <= enter_done && timeout_hit;

      if (state_q == S_LATCH) begin
        wait_cnt <= '0;
      end else if (state_q == S_WAIT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end

      if (setup) begin
        RamBusAddress <= PADDR;
        RamBusDataIn  <= PWDATA;
        RamBusWrnRd   <= PWRITE;
      end

      if (enter_done) begin
        if (RamBusWrnRd) begin
          PRDATA <= '0;
        end else if (timeout_hit) begin
          PRDATA <= ERR_DATA;
        end else begin
          PRDATA <= RamBusDataOut;
        end
        if (timeout_hit && (TimeoutCount != 16'hFFFF)) begin
          TimeoutCount <= TimeoutCount + 16'd1;
        end
      end
    end
  end

endmodule
